sdram_arbit: RTL

Top-level command arbiter for the SDRAM controller. Passes the power-up init sequence through to the SDRAM bus, then grants the bus to auto-refresh, write or read, one at a time. It drives each sub-module's enable and multiplexes that sub-module's command, address and bank onto the SDRAM pins. It sits directly downstream of the init, auto-refresh, write and read generators and consumes their request and end flags.

---
 rtl/sdram_arbit_if.sv | 45 ++++
 rtl/sdram_arbit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sdram_arbit_if.sv
// Signal bundle between the SDRAM command generators (init, refresh, write, read)
// and the command arbiter: request/end flags, per-stage buses, grants and SDRAM pins.
interface sdram_arbit_if;
    logic        flag_init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        flag_aref_ask;
    logic        flag_aref_end;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;
    logic        wr_ask;
    logic        flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        rd_ask;
    logic        flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        aref_en;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;

    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        input  flag_aref_ask, flag_aref_end, aref_cmd, aref_addr,
        input  wr_ask, flag_wr_end, wr_cmd, wr_addr, wr_bank,
        input  rd_ask, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        output aref_en, wr_en, rd_en,
        output sdram_cmd, sdram_addr, sdram_bank
    );

    modport master (
        output flag_init_end, init_cmd, init_addr,
        output flag_aref_ask, flag_aref_end, aref_cmd, aref_addr,
        output wr_ask, flag_wr_end, wr_cmd, wr_addr, wr_bank,
        output rd_ask, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        input  aref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_addr, sdram_bank
    );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: passes init through, then grants refresh/write/read one at a time.
// Define SDRAM_ARBIT_OUT_REG_EN to register the SDRAM pins (one extra cycle of latency).
module sdram_arbit #(
    parameter logic [3:0]  NOP_CMD   = 4'b0111,
    parameter logic [11:0] IDLE_ADDR = 12'd0
) (
    input  logic         sclk,
    input  logic         srst_n,
    sdram_arbit_if.slave arb
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_e;

    localparam logic LG_READ  = 1'b0;
    localparam logic LG_WRITE = 1'b1;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        aref_en_q, wr_en_q, rd_en_q;
    logic [3:0]  cmd_s;
    logic [11:0] addr_s;
    logic [1:0]  bank_s;

    // State, fairness bit and grant flops
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q      <= ST_INIT;
            last_grant_q <= LG_READ;
            aref_en_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            aref_en_q    <= (state_d == ST_AREF);
            wr_en_q      <= (state_d == ST_WRITE);
            rd_en_q      <= (state_d == ST_READ);
        end
    end

    // Next-state logic; every owner returns through ARBIT so the bus sees at least one NOP
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_INIT: begin
                if (arb.flag_init_end) state_d = ST_ARBIT;
                else                   state_d = ST_INIT;
            end
            ST_ARBIT: begin
                if (arb.flag_aref_ask) begin
                    state_d = ST_AREF;
                end else if (arb.wr_ask && (!arb.rd_ask || (last_grant_q == LG_READ))) begin
                    state_d      = ST_WRITE;
                    last_grant_d = LG_WRITE;
                end else if (arb.rd_ask) begin
                    state_d      = ST_READ;
                    last_grant_d = LG_READ;
                end else begin
                    state_d = ST_ARBIT;
                end
            end
            ST_AREF: begin
                if (arb.flag_aref_end) state_d = ST_ARBIT;
                else                   state_d = ST_AREF;
            end
            ST_WRITE: begin
                if (arb.flag_wr_end) state_d = ST_ARBIT;
                else                 state_d = ST_WRITE;
            end
            ST_READ: begin
                if (arb.flag_rd_end) state_d = ST_ARBIT;
                else                 state_d = ST_READ;
            end
            default: begin
                state_d      = ST_INIT;
                last_grant_d = LG_READ;
            end
        endcase
    end

    // Bus mux: the current owner's command, address and bank
    always_comb begin
        cmd_s  = NOP_CMD;
        addr_s = IDLE_ADDR;
        bank_s = 2'd0;
        case (state_q)
            ST_INIT: begin
                cmd_s  = arb.init_cmd;
                addr_s = arb.init_addr;
            end
            ST_AREF: begin
                cmd_s  = arb.aref_cmd;
                addr_s = arb.aref_addr;
            end
            ST_WRITE: begin
                cmd_s  = arb.wr_cmd;
                addr_s = arb.wr_addr;
                bank_s = arb.wr_bank;
            end
            ST_READ: begin
                cmd_s  = arb.rd_cmd;
                addr_s = arb.rd_addr;
                bank_s = arb.rd_bank;
            end
            default: begin
                cmd_s  = NOP_CMD;
                addr_s = IDLE_ADDR;
                bank_s = 2'd0;
            end
        endcase
    end

    assign arb.aref_en = aref_en_q;
    assign arb.wr_en   = wr_en_q;
    assign arb.rd_en   = rd_en_q;

`ifdef SDRAM_ARBIT_OUT_REG_EN
    logic [3:0]  cmd_q;
    logic [11:0] addr_q;
    logic [1:0]  bank_q;

    // Pin register
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            cmd_q  <= NOP_CMD;
            addr_q <= IDLE_ADDR;
            bank_q <= 2'd0;
        end else begin
            cmd_q  <= cmd_s;
            addr_q <= addr_s;
            bank_q <= bank_s;
        end
    end

    assign arb.sdram_cmd  = cmd_q;
    assign arb.sdram_addr = addr_q;
    assign arb.sdram_bank = bank_q;
`else
    // Reset must force NOP at once even though INIT otherwise passes init_cmd straight through
    assign arb.sdram_cmd  = srst_n ? cmd_s  : NOP_CMD;
    assign arb.sdram_addr = srst_n ? addr_s : IDLE_ADDR;
    assign arb.sdram_bank = srst_n ? bank_s : 2'd0;
`endif

endmodule
